// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM pipeline stage: datapath width, default memory
// mapping and the access FSM state encodings.
package mem_stage_pkg;

    localparam int WORD     = 32;
    localparam int ADDR_W   = 16;
    localparam int MEM_BASE = 1024;
    localparam int DEST_W   = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/mem_stage_if.sv
// Word-addressed data-memory handshake bus between the MEM stage (master)
// and the external memory (slave).
interface mem_stage_if #(
    parameter int WORD   = 32,
    parameter int ADDR_W = 16
);

    logic [ADDR_W-1:0] mem_addr;
    logic [WORD-1:0]   mem_wdata;
    logic              mem_re;
    logic              mem_we;
    logic [WORD-1:0]   mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_addr, mem_wdata, mem_re, mem_we,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_re, mem_we,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB boundary register: loads whenever the stage is not stalled, holds
// otherwise, synchronous active-high reset.
module mem_wb_reg #(
    parameter int WORD = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            wb_en_i,
    input  logic            mem_r_en_i,
    input  logic [3:0]      dest_i,
    input  logic [WORD-1:0] alu_i,
    input  logic [WORD-1:0] data_i,
    output logic            wb_en_o,
    output logic            mem_r_en_o,
    output logic [3:0]      dest_o,
    output logic [WORD-1:0] alu_o,
    output logic [WORD-1:0] data_o
);

    logic            wb_en_q;
    logic            mem_r_en_q;
    logic [3:0]      dest_q;
    logic [WORD-1:0] alu_q;
    logic [WORD-1:0] data_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            dest_q     <= '0;
            alu_q      <= '0;
            data_q     <= '0;
        end else if (en_i) begin
            wb_en_q    <= wb_en_i;
            mem_r_en_q <= mem_r_en_i;
            dest_q     <= dest_i;
            alu_q      <= alu_i;
            data_q     <= data_i;
        end
    end

    assign wb_en_o    = wb_en_q;
    assign mem_r_en_o = mem_r_en_q;
    assign dest_o     = dest_q;
    assign alu_o      = alu_q;
    assign data_o     = data_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: multi-cycle data-memory handshake with upstream stall and
// MEM/WB register. Optional misalignment trap enabled by MEM_ALIGN_CHECK_EN.
module mem_stage #(
    parameter int WORD     = mem_stage_pkg::WORD,
    parameter int ADDR_W   = mem_stage_pkg::ADDR_W,
    parameter int MEM_BASE = mem_stage_pkg::MEM_BASE
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            mem_read,
    input  logic                            mem_write,
    input  logic                            wb_en_in,
    input  logic [mem_stage_pkg::DEST_W-1:0] dest_in,
    input  logic [WORD-1:0]                 alu_result,
    input  logic [WORD-1:0]                 val_Rm,
    output logic                            stall,
    mem_stage_if.master                     mem_bus,
    output logic                            wb_en,
    output logic                            mem_r_en,
    output logic [mem_stage_pkg::DEST_W-1:0] dest,
    output logic [WORD-1:0]                 alu_result_out,
    output logic [WORD-1:0]                 mem_data_out,
    output logic                            align_fault
);

    import mem_stage_pkg::*;

    logic              access;
    logic              is_load;
    logic              in_req;
    logic [1:0]        state_q, state_d;
    logic [WORD-1:0]   offset;
    logic [ADDR_W-1:0] word_addr;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD-1:0]   wdata_q;
    logic [WORD-1:0]   rdata_q;
    logic              re_q, we_q;
    logic              wb_en_gated;

    assign access    = mem_read | mem_write;
    assign is_load   = mem_read & ~mem_write;
    assign offset    = alu_result - WORD'(MEM_BASE);
    assign word_addr = ADDR_W'(offset >> 2);
    assign in_req    = (state_q == ST_REQ) || (state_q == ST_WAIT);

    // DONE releases the stall so upstream advances exactly once per access.
    assign stall = access & (state_q != ST_DONE);

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned;
    logic fault_q;
    assign misaligned = |alu_result[1:0];
`endif

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
`ifdef MEM_ALIGN_CHECK_EN
                    state_d = misaligned ? ST_DONE : ST_REQ;
`else
                    state_d = ST_REQ;
`endif
                end
            end
            ST_REQ, ST_WAIT: state_d = mem_bus.mem_ready ? ST_DONE : ST_WAIT;
            default:         state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            // REQ is only ever entered from IDLE, so this is the capture edge.
            if (state_d == ST_REQ) begin
                addr_q  <= word_addr;
                wdata_q <= val_Rm;
                re_q    <= is_load;
                we_q    <= mem_write;
            end else if (state_d != ST_WAIT) begin
                re_q <= 1'b0;
                we_q <= 1'b0;
            end
            if (in_req && mem_bus.mem_ready) begin
                rdata_q <= mem_bus.mem_rdata;
            end
`ifdef MEM_ALIGN_CHECK_EN
            fault_q <= (state_q == ST_IDLE) && (state_d == ST_DONE);
            if ((state_q == ST_IDLE) && (state_d == ST_DONE)) begin
                rdata_q <= '0;
            end
`endif
        end
    end

    assign mem_bus.mem_addr  = addr_q;
    assign mem_bus.mem_wdata = wdata_q;
    assign mem_bus.mem_re    = re_q;
    assign mem_bus.mem_we    = we_q;

`ifdef MEM_ALIGN_CHECK_EN
    assign align_fault = fault_q;
    assign wb_en_gated = wb_en_in & ~fault_q;
`else
    assign align_fault = 1'b0;
    assign wb_en_gated = wb_en_in;
`endif

    mem_wb_reg #(
        .WORD (WORD)
    ) u_mem_wb_reg (
        .clk        (clk),
        .rst        (rst),
        .en_i       (~stall),
        .wb_en_i    (wb_en_gated),
        .mem_r_en_i (is_load),
        .dest_i     (dest_in),
        .alu_i      (alu_result),
        .data_i     (rdata_q),
        .wb_en_o    (wb_en),
        .mem_r_en_o (mem_r_en),
        .dest_o     (dest),
        .alu_o      (alu_result_out),
        .data_o     (mem_data_out)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; define MEM_ALIGN_CHECK_EN to
// exercise the misalignment trap instead of the plain misaligned load.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, wb_en_in;
    logic [3:0]  dest_in;
    logic [31:0] alu_result, val_Rm;
    logic        stall, wb_en, mem_r_en, align_fault;
    logic [3:0]  dest;
    logic [31:0] alu_result_out, mem_data_out;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    mem_stage_if #(.WORD(32), .ADDR_W(16)) bus ();

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .wb_en_in       (wb_en_in),
        .dest_in        (dest_in),
        .alu_result     (alu_result),
        .val_Rm         (val_Rm),
        .stall          (stall),
        .mem_bus        (bus.master),
        .wb_en          (wb_en),
        .mem_r_en       (mem_r_en),
        .dest           (dest),
        .alu_result_out (alu_result_out),
        .mem_data_out   (mem_data_out),
        .align_fault    (align_fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic rd, input logic wr, input logic wbe, input logic [3:0] d,
                          input logic [31:0] alu, input logic [31:0] rm);
        mem_read   = rd;
        mem_write  = wr;
        wb_en_in   = wbe;
        dest_in    = d;
        alu_result = alu;
        val_Rm     = rm;
    endtask

    // Plays the memory side: asserts mem_ready once `delay` request cycles have
    // passed, checks the request lines, and returns after the output-register edge.
    task automatic do_access(input int delay, input logic [15:0] exp_addr, input logic [31:0] exp_wdata,
                             input bit is_wr, output int stall_n, output int req_n,
                             output int first_req, output int last_req);
        int k;
        stall_n   = 0;
        req_n     = 0;
        first_req = -1;
        last_req  = -1;
        for (k = 0; k < 50; k++) begin
            #1;
            if (!stall) break;
            stall_n++;
            if (bus.mem_re || bus.mem_we) begin
                req_n++;
                if (first_req < 0) first_req = cyc;
                last_req = cyc;
                if (req_n == 1 || delay > 0) begin
                    check("req_addr", 32'(bus.mem_addr), 32'(exp_addr));
                    check("req_dir", {30'd0, bus.mem_we, bus.mem_re}, is_wr ? 32'd2 : 32'd1);
                    if (is_wr) check("req_wdata", bus.mem_wdata, exp_wdata);
                end
                bus.mem_ready = (req_n > delay);
            end else begin
                bus.mem_ready = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        check("access_bounded", (k < 50) ? 32'd1 : 32'd0, 32'd1);
        check("req_off_in_done", {31'd0, bus.mem_re | bus.mem_we}, 32'd0);
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int s_n, r_n, f1, l1, f2, l2;

        rst = 1'b1;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        set_in(0, 0, 0, 4'd0, 32'd0, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_wb_en", {31'd0, wb_en}, 32'd0);
        check("rst_mem_r_en", {31'd0, mem_r_en}, 32'd0);
        check("rst_dest", {28'd0, dest}, 32'd0);
        check("rst_alu_out", alu_result_out, 32'd0);
        check("rst_data_out", mem_data_out, 32'd0);
        check("rst_req", {30'd0, bus.mem_we, bus.mem_re}, 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_fault", {31'd0, align_fault}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);

        // Non-memory op: single-cycle pass-through, never stalls.
        set_in(0, 0, 1, 4'd3, 32'h12, 32'h0);
        #1;
        check("alu_stall", {31'd0, stall}, 32'd0);
        tick();
        check("alu_wb_en", {31'd0, wb_en}, 32'd1);
        check("alu_dest", {28'd0, dest}, 32'd3);
        check("alu_out", alu_result_out, 32'h12);
        check("alu_mem_r_en", {31'd0, mem_r_en}, 32'd0);

        // Load at 1028, ready in the first REQ cycle.
        set_in(1, 0, 1, 4'd5, 32'd1028, 32'h0);
        bus.mem_rdata = 32'hDEADBEEF;
        do_access(0, 16'd1, 32'h0, 1'b0, s_n, r_n, f1, l1);
        check("ld_stall_cycles", 32'(s_n), 32'd2);
        check("ld_req_cycles", 32'(r_n), 32'd1);
        check("ld_data", mem_data_out, 32'hDEADBEEF);
        check("ld_mem_r_en", {31'd0, mem_r_en}, 32'd1);
        check("ld_dest", {28'd0, dest}, 32'd5);
        check("ld_alu_out", alu_result_out, 32'd1028);

        // Store at 1032, ready after three extra wait cycles.
        set_in(0, 1, 0, 4'd0, 32'd1032, 32'hA5A5A5A5);
        bus.mem_rdata = 32'h0;
        do_access(3, 16'd2, 32'hA5A5A5A5, 1'b1, s_n, r_n, f1, l1);
        check("st_req_cycles", 32'(r_n), 32'd4);
        check("st_stall_cycles", 32'(s_n), 32'd5);
        check("st_mem_r_en", {31'd0, mem_r_en}, 32'd0);
        check("st_wb_en", {31'd0, wb_en}, 32'd0);
        check("st_alu_out", alu_result_out, 32'd1032);

        // Read and write both set: treated as a write, mem_r_en registered 0.
        set_in(1, 1, 0, 4'd2, 32'd1048, 32'h0F0F0F0F);
        do_access(1, 16'd6, 32'h0F0F0F0F, 1'b1, s_n, r_n, f1, l1);
        check("rw_req_cycles", 32'(r_n), 32'd2);
        check("rw_mem_r_en", {31'd0, mem_r_en}, 32'd0);

        // Back-to-back loads at 1024 and 1036.
        set_in(1, 0, 1, 4'd8, 32'd1024, 32'h0);
        bus.mem_rdata = 32'h11111111;
        do_access(0, 16'd0, 32'h0, 1'b0, s_n, r_n, f1, l1);
        check("b2b_first_data", mem_data_out, 32'h11111111);
        set_in(1, 0, 1, 4'd9, 32'd1036, 32'h0);
        bus.mem_rdata = 32'h22222222;
        do_access(0, 16'd3, 32'h0, 1'b0, s_n, r_n, f2, l2);
        check("b2b_gap", 32'(f2 - l1), 32'd3);
        check("b2b_second_data", mem_data_out, 32'h22222222);
        check("b2b_second_dest", {28'd0, dest}, 32'd9);

        // Reset during WAIT; the late mem_ready must be ignored.
        set_in(1, 0, 1, 4'd6, 32'd1040, 32'h0);
        bus.mem_rdata = 32'h12345678;
        tick();
        tick();
        check("pre_rst_re", {31'd0, bus.mem_re}, 32'd1);
        rst = 1'b1;
        set_in(0, 0, 0, 4'd0, 32'd0, 32'd0);
        tick();
        rst = 1'b0;
        check("mid_rst_req", {30'd0, bus.mem_we, bus.mem_re}, 32'd0);
        check("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
        check("mid_rst_wb_en", {31'd0, wb_en}, 32'd0);
        check("mid_rst_data", mem_data_out, 32'd0);
        bus.mem_ready = 1'b1;
        tick();
        tick();
        check("late_ready_req", {30'd0, bus.mem_we, bus.mem_re}, 32'd0);
        bus.mem_ready = 1'b0;
        set_in(0, 0, 1, 4'd7, 32'h99, 32'h0);
        tick();
        check("late_ready_no_latch", mem_data_out, 32'd0);
        check("post_rst_dest", {28'd0, dest}, 32'd7);

        // Misaligned load at 1025.
        set_in(1, 0, 1, 4'd4, 32'd1025, 32'h0);
        bus.mem_rdata = 32'hCAFEF00D;
`ifdef MEM_ALIGN_CHECK_EN
        #1;
        check("mis_idle_stall", {31'd0, stall}, 32'd1);
        tick();
        check("mis_done_stall", {31'd0, stall}, 32'd0);
        check("mis_fault_pulse", {31'd0, align_fault}, 32'd1);
        check("mis_no_req", {30'd0, bus.mem_we, bus.mem_re}, 32'd0);
        tick();
        check("mis_fault_clear", {31'd0, align_fault}, 32'd0);
        check("mis_wb_en", {31'd0, wb_en}, 32'd0);
        check("mis_data", mem_data_out, 32'd0);
`else
        do_access(0, 16'd0, 32'h0, 1'b0, s_n, r_n, f1, l1);
        check("mis_req_cycles", 32'(r_n), 32'd1);
        check("mis_data", mem_data_out, 32'hCAFEF00D);
        check("mis_wb_en", {31'd0, wb_en}, 32'd1);
        check("mis_fault", {31'd0, align_fault}, 32'd0);
`endif

        set_in(0, 0, 0, 4'd0, 32'd0, 32'd0);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the ALU result as an effective address and `val_Rm` as store data.
- Runs a multi-cycle handshake to an external word-addressed data memory and stalls the pipeline while an access is outstanding.
- Registers the result into the MEM/WB boundary for the write-back stage.

Parameters:
- WORD, 32, datapath width
- ADDR_W, 16, external memory word-address width
- MEM_BASE, 1024, byte address mapped to external word 0

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- mem_read  input  1  load instruction present at stage input
- mem_write  input  1  store instruction present at stage input
- wb_en_in  input  1  instruction writes a register
- dest_in  input  4  destination register index
- alu_result  input  WORD  effective byte address / ALU value from execute
- val_Rm  input  WORD  store data
- stall  output  1  hold all upstream stages this cycle
- mem_addr  output  ADDR_W  external word address
- mem_wdata  output  WORD  external write data
- mem_re  output  1  external read request
- mem_we  output  1  external write request
- mem_rdata  input  WORD  external read data, valid when mem_ready=1
- mem_ready  input  1  external access complete
- wb_en  output  1  registered write-enable to WB
- mem_r_en  output  1  registered: WB selects memory data
- dest  output  4  registered destination
- alu_result_out  output  WORD  registered ALU value
- mem_data_out  output  WORD  registered load data
- align_fault  output  1  one-cycle misaligned-access pulse (see Optional Feature)

Behaviour:
- Reset values: all registered outputs 0, `mem_re`/`mem_we` 0, `mem_addr`/`mem_wdata` 0, FSM in IDLE, `align_fault` 0.
- Reset is synchronous and dominates everything, including mid-access: FSM goes to IDLE and requests drop next edge. A `mem_ready` arriving afterwards is ignored.
- `access = mem_read | mem_write`. If both are high, the access is a write: `mem_r_en` is registered 0.
- Address: `mem_addr = ((alu_result - MEM_BASE) >> 2)[ADDR_W-1:0]`. Captured together with `mem_wdata = val_Rm` on the IDLE->REQ edge and held constant until DONE.
- FSM, one-hot or binary, states IDLE, REQ, WAIT, DONE:
  - IDLE: access=1 -> REQ; otherwise stay.
  - REQ: `mem_re`/`mem_we` asserted. mem_ready=1 -> latch `mem_rdata` into the load buffer, go DONE; else -> WAIT.
  - WAIT: requests stay asserted. mem_ready=1 -> latch data, go DONE; else stay (no timeout).
  - DONE: requests deasserted -> IDLE.
- Requests are registered outputs, high only in REQ and WAIT.
- `stall` is combinational: `access & (state != DONE)`. It is 0 for non-memory instructions, and 0 in DONE so upstream advances exactly once.
- Output register loads on every edge where `stall = 0`, from `wb_en_in`, `dest_in`, `alu_result`, `mem_read & ~mem_write`, and the load buffer. It holds while `stall = 1`, so WB never sees a half-finished access.
- Latency:
  - Non-memory instruction: 1 cycle.
  - Memory instruction: N+2 cycles, where N ≥ 1 is the number of REQ/WAIT cycles until mem_ready.
- Back-to-back accesses: DONE->IDLE->REQ, so one idle cycle between accesses.
- `mem_ready` in IDLE or DONE is ignored.
- A store keeps `wb_en_in` as given; upstream already clears it.

Optional Feature:
- Macro `MEM_ALIGN_CHECK_EN`.
- When defined:
  - An access with `alu_result[1:0] != 0` skips REQ/WAIT and goes IDLE->DONE; no request is issued.
  - `align_fault` pulses 1 in that DONE cycle.
  - The registered `wb_en` is forced 0 and `mem_data_out` is 0.
- When undefined:
  - Low two address bits are ignored.
  - `align_fault` is tied 0.
  - FSM has no IDLE->DONE arc.

Decomposition:
- Shared package/defines file holds WORD, state encodings (IDLE=0, REQ=1, WAIT=2, DONE=3) and the default MEM_BASE.
- One natural sub-module: `mem_wb_reg`, the enable-gated MEM/WB output register with synchronous reset.
- FSM and address arithmetic stay in `mem_stage`.

Test Plan:
- ALU op (mem_read=0, mem_write=0, alu_result=0x12, wb_en_in=1, dest_in=3) -> stall stays 0; next edge wb_en=1, dest=3, alu_result_out=0x12, mem_r_en=0.
- Load with alu_result=1028, mem_ready high in the first REQ cycle, mem_rdata=0xDEADBEEF -> mem_addr=1, mem_re high 1 cycle, stall high 2 cycles; after DONE, mem_data_out=0xDEADBEEF and mem_r_en=1.
- Store with alu_result=1032, val_Rm=0xA5A5A5A5, mem_ready delayed 3 cycles -> mem_we high 4 cycles, mem_addr=2, mem_wdata constant throughout; stall released only in DONE.
- Load issued, rst pulsed during WAIT, then mem_ready=1 -> outputs all 0, state IDLE, no data latched.
- Two back-to-back loads at 1024 and 1036 -> mem_addr 0 then 3, with exactly one idle cycle between request windows.
- With MEM_ALIGN_CHECK_EN: load at 1025 -> no mem_re, align_fault=1 for one cycle, wb_en=0. Without the macro: mem_addr=0, normal load.
